// File: rtl/life_ring_buf.sv
// Game-of-Life cell store: an X*Y-bit ring rotated LANES cells per enabled clock,
// with a rotation-phase tracker so cursor edits land on absolute board cells.
//
// state    | meaning
// ST_IDLE  | waiting for a key release edge; edit_busy low
// ST_APPLY | edit captured; applied to the ring at the next edge
module life_ring_buf #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   shift_en_i,
    input  logic [LANES-1:0]       in_bits_i,
    output logic [LANES-1:0]       out_bits_o,
    input  logic                   key_flip_i,
    input  logic                   key_flip_d_i,
    input  logic [1:0]             edit_mode_i,
    input  logic [LOG2X-1:0]       cursor_x_i,
    input  logic [LOG2Y-1:0]       cursor_y_i,
    output logic [LOG2X+LOG2Y-1:0] phase_o,
    output logic                   gen_done_o,
    output logic [15:0]            gen_count_o,
    output logic                   edit_busy_o
);
    localparam int N  = X * Y;
    localparam int PW = LOG2X + LOG2Y;
    localparam logic [PW:0]    N_W     = (PW+1)'(N);
    localparam logic [PW:0]    LANES_W = (PW+1)'(LANES);
    localparam logic [LOG2X:0] X_W     = (LOG2X+1)'(X);
    localparam logic [LOG2Y:0] Y_W     = (LOG2Y+1)'(Y);

    generate
        if ((N % LANES) != 0 || LANES >= N) begin : g_bad_lanes
            $error("life_ring_buf: LANES must divide X*Y and be smaller than it");
        end
        if ((1 << LOG2X) < X || (1 << LOG2Y) < Y) begin : g_bad_cursor
            $error("life_ring_buf: cursor widths too narrow for board size");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ring_q, ring_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            gen_done_q, gen_done_d;
    logic [15:0]     gen_count_q, gen_count_d;
    logic [1:0]      mode_q, mode_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;

    logic [PW:0]     phase_sum;
    logic [PW:0]     diff;
    logic [PW-1:0]   lin;
    logic [N-1:0]    mask;

    assign lin = PW'(32'(cursor_y_i) * 32'(X) + 32'(cursor_x_i));

    always_comb begin
        state_d     = state_q;
        ring_d      = ring_q;
        phase_d     = phase_q;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        phase_sum   = {1'b0, phase_q} + LANES_W;
        diff        = '0;
        mask        = '0;

        if (shift_en_i) begin
            ring_d  = {in_bits_i, ring_q[N-1:LANES]};
            phase_d = (phase_sum >= N_W) ? PW'(phase_sum - N_W) : phase_sum[PW-1:0];
            if (phase_d == '0) begin
                gen_done_d  = 1'b1;
                gen_count_d = gen_count_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (key_flip_d_i && !key_flip_i) begin
                    state_d = ST_APPLY;
                    mode_d  = edit_mode_i;
                    idx_d   = lin;
                    valid_d = ({1'b0, cursor_x_i} < X_W) && ({1'b0, cursor_y_i} < Y_W);
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                if (valid_q) begin
                    if (mode_q == 2'b11) begin
                        ring_d      = '0;
                        gen_count_d = '0;
                    end else begin
                        // Physical slot of the logical cell after this edge's rotation.
                        diff = {1'b0, idx_q} - {1'b0, phase_d};
                        if (diff[PW]) begin
                            diff = diff + N_W;
                        end
                        mask = {{(N-1){1'b0}}, 1'b1} << diff[PW-1:0];
                        case (mode_q)
                            2'b00:   ring_d = ring_d ^ mask;
                            2'b01:   ring_d = ring_d | mask;
                            default: ring_d = ring_d & ~mask;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            ring_q      <= '0;
            phase_q     <= '0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
            mode_q      <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_q      <= ring_d;
            phase_q     <= phase_d;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
        end
    end

    assign out_bits_o  = ring_q[LANES-1:0];
    assign phase_o     = phase_q;
    assign gen_done_o  = gen_done_q;
    assign gen_count_o = gen_count_q;
    assign edit_busy_o = (state_q == ST_APPLY);

endmodule

// File: tb/tb_life_ring_buf.sv
// Directed bench for life_ring_buf: three instances (8x8/1 lane, 8x8/4 lanes, 6x8/1 lane)
// with loopback recirculation; board contents read back by rotating a full generation.
module tb_life_ring_buf;
    logic clk = 1'b0;
    logic rst_n;
    logic se8, se4, se6, loop;
    logic kf, kd8, kd4, kd6;
    logic [1:0] mode;
    logic [3:0] cx;
    logic [2:0] cy;
    logic       r8, r6;
    logic [3:0] r4;
    logic       in8, out8, in6, out6;
    logic [3:0] in4, out4;
    logic [5:0] ph8o, ph4o;
    logic [6:0] ph6o;
    logic       gd8, gd4, gd6, bz8, bz4, bz6;
    logic [15:0] gc8o, gc4o, gc6o;

    int total = 0;
    int bad = 0;
    int ph8 = 0, gc8 = 0, ph4 = 0, gc4 = 0, ph6 = 0;

    always #5 clk = ~clk;

    assign in8 = loop ? out8 : r8;
    assign in4 = loop ? out4 : r4;
    assign in6 = loop ? out6 : r6;

    life_ring_buf #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .LANES(1)) u8 (
        .clk_i(clk), .reset_ni(rst_n), .shift_en_i(se8), .in_bits_i(in8), .out_bits_o(out8),
        .key_flip_i(kf), .key_flip_d_i(kd8), .edit_mode_i(mode), .cursor_x_i(cx[2:0]),
        .cursor_y_i(cy), .phase_o(ph8o), .gen_done_o(gd8), .gen_count_o(gc8o), .edit_busy_o(bz8));

    life_ring_buf #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .LANES(4)) u4 (
        .clk_i(clk), .reset_ni(rst_n), .shift_en_i(se4), .in_bits_i(in4), .out_bits_o(out4),
        .key_flip_i(kf), .key_flip_d_i(kd4), .edit_mode_i(mode), .cursor_x_i(cx[2:0]),
        .cursor_y_i(cy), .phase_o(ph4o), .gen_done_o(gd4), .gen_count_o(gc4o), .edit_busy_o(bz4));

    life_ring_buf #(.X(6), .Y(8), .LOG2X(4), .LOG2Y(3), .LANES(1)) u6 (
        .clk_i(clk), .reset_ni(rst_n), .shift_en_i(se6), .in_bits_i(in6), .out_bits_o(out6),
        .key_flip_i(kf), .key_flip_d_i(kd6), .edit_mode_i(mode), .cursor_x_i(cx),
        .cursor_y_i(cy), .phase_o(ph6o), .gen_done_o(gd6), .gen_count_o(gc6o), .edit_busy_o(bz6));

    // One clock; phase/generation models follow the shift enables.
    task automatic step();
        @(posedge clk);
        #1;
        if (se8) begin
            ph8 = (ph8 + 1) % 64;
            if (ph8 == 0) gc8++;
        end
        if (se4) begin
            ph4 = (ph4 + 4) % 64;
            if (ph4 == 0) gc4++;
        end
        if (se6) ph6 = (ph6 + 1) % 48;
    endtask

    task automatic edit8(input logic [1:0] m, input logic [3:0] x, input logic [2:0] y);
        kd8 = 1'b1; kf = 1'b0; mode = m; cx = x; cy = y;
        step();
        kd8 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; loop = 1'b0; se8 = 1'b1; se4 = 1'b1; se6 = 1'b1;
        kf = 1'b0; kd8 = 1'b0; kd4 = 1'b0; kd6 = 1'b0; mode = 2'b00; cx = '0; cy = '0;
        repeat (3) begin
            r8 = 1'($urandom); r4 = 4'($urandom); r6 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        total++; if (out8 !== 1'b0) begin bad++; $display("FAIL reset_out8 got=%b want=0", out8); end
        total++; if (ph8o !== 6'd0) begin bad++; $display("FAIL reset_phase8 got=%0d want=0", ph8o); end
        total++; if (gc8o !== 16'd0) begin bad++; $display("FAIL reset_gcount8 got=%0d want=0", gc8o); end
        total++; if (gd8 !== 1'b0) begin bad++; $display("FAIL reset_gdone8 got=%b want=0", gd8); end
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b want=0", bz8); end
        total++; if (out4 !== 4'd0) begin bad++; $display("FAIL reset_out4 got=%h want=0", out4); end
        total++; if (ph4o !== 6'd0) begin bad++; $display("FAIL reset_phase4 got=%0d want=0", ph4o); end
        total++; if (ph6o !== 7'd0) begin bad++; $display("FAIL reset_phase6 got=%0d want=0", ph6o); end
        se8 = 1'b0; se4 = 1'b0; se6 = 1'b0; loop = 1'b1; rst_n = 1'b1;
        ph8 = 0; gc8 = 0; ph4 = 0; gc4 = 0; ph6 = 0;
        step();
        total++; if (ph8o !== 6'd0) begin bad++; $display("FAIL idle_phase8 got=%0d want=0", ph8o); end
    endtask

    task automatic test_recirc();
        int pulses;
        se8 = 1'b1;
        repeat (5) step();
        total++; if (ph8o !== 6'd5) begin bad++; $display("FAIL recirc_phase5 got=%0d want=5", ph8o); end
        se8 = 1'b0;
        kd8 = 1'b1; mode = 2'b01; cx = 4'd2; cy = 3'd1;
        step();
        total++; if (bz8 !== 1'b1) begin bad++; $display("FAIL recirc_busy_set got=%b want=1", bz8); end
        kd8 = 1'b0;
        step();
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL recirc_busy_clr got=%b want=0", bz8); end
        total++; if (out8 !== 1'b0) begin bad++; $display("FAIL recirc_out_ph5 got=%b want=0", out8); end
        se8 = 1'b1;
        repeat (4) step();
        total++; if (out8 !== 1'b0) begin bad++; $display("FAIL recirc_out_ph9 got=%b want=0", out8); end
        step();
        total++; if (out8 !== 1'b1) begin bad++; $display("FAIL recirc_out_ph10 got=%b want=1", out8); end
        total++; if (ph8o !== 6'd10) begin bad++; $display("FAIL recirc_phase10 got=%0d want=10", ph8o); end
        pulses = 0;
        repeat (64) begin
            step();
            if (gd8 === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL recirc_gdone_pulses got=%0d want=1", pulses); end
        total++; if (out8 !== 1'b1) begin bad++; $display("FAIL recirc_out_again got=%b want=1", out8); end
        total++; if (gc8o !== 16'd1) begin bad++; $display("FAIL recirc_gcount got=%0d want=1", gc8o); end
    endtask

    task automatic test_lanes4();
        int pulses;
        pulses = 0;
        se4 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            total++;
            if (ph4o !== 6'((4 * k) % 64)) begin
                bad++; $display("FAIL lanes4_phase step=%0d got=%0d want=%0d", k, ph4o, (4 * k) % 64);
            end
            if (gd4 === 1'b1) pulses++;
        end
        se4 = 1'b0;
        total++; if (pulses != 2) begin bad++; $display("FAIL lanes4_gdone_pulses got=%0d want=2", pulses); end
        total++; if (gc4o !== 16'd2) begin bad++; $display("FAIL lanes4_gcount got=%0d want=2", gc4o); end
    endtask

    task automatic test_toggle_clear();
        int ones;
        se8 = 1'b1;
        edit8(2'b00, 4'd7, 3'd7);
        repeat ((63 - ph8 + 64) % 64) step();
        total++; if (out8 !== 1'b1) begin bad++; $display("FAIL toggle1_cell63 got=%b want=1", out8); end
        edit8(2'b00, 4'd7, 3'd7);
        repeat ((10 - ph8 + 64) % 64) step();
        total++; if (out8 !== 1'b1) begin bad++; $display("FAIL toggle_cell10_kept got=%b want=1", out8); end
        repeat ((63 - ph8 + 64) % 64) step();
        total++; if (out8 !== 1'b0) begin bad++; $display("FAIL toggle2_cell63 got=%b want=0", out8); end
        repeat (63) step();
        total++; if (gc8o !== 16'(gc8)) begin bad++; $display("FAIL pre_clear_gcount got=%0d want=%0d", gc8o, gc8); end
        // clear-all lands on the same edge as the generation wrap
        edit8(2'b11, 4'd0, 3'd0);
        gc8 = 0;
        total++; if (gc8o !== 16'd0) begin bad++; $display("FAIL clear_gcount got=%0d want=0", gc8o); end
        total++; if (gd8 !== 1'b1) begin bad++; $display("FAIL clear_gdone got=%b want=1", gd8); end
        total++; if (ph8o !== 6'd0) begin bad++; $display("FAIL clear_phase got=%0d want=0", ph8o); end
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", bz8); end
        ones = 0;
        repeat (64) begin
            if (out8 !== 1'b0) ones++;
            step();
        end
        total++; if (ones != 0) begin bad++; $display("FAIL clear_ring_ones got=%0d want=0", ones); end
        total++; if (gc8o !== 16'd1) begin bad++; $display("FAIL clear_gcount_after got=%0d want=1", gc8o); end
    endtask

    task automatic test_busy_drop();
        logic [63:0] img;
        se8 = 1'b0;
        kd8 = 1'b1; kf = 1'b0; mode = 2'b01; cx = 4'd3; cy = 3'd0;
        step();
        total++; if (bz8 !== 1'b1) begin bad++; $display("FAIL drop_busy1 got=%b want=1", bz8); end
        cx = 4'd5;
        step();
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL drop_busy2 got=%b want=0", bz8); end
        kd8 = 1'b0;
        step();
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL drop_busy3 got=%b want=0", bz8); end
        se8 = 1'b1;
        img = '0;
        for (int i = 0; i < 64; i++) begin
            img[ph8] = out8;
            step();
        end
        total++; if (img !== 64'h8) begin bad++; $display("FAIL drop_board got=%h want=%h", img, 64'h8); end
    endtask

    task automatic test_range();
        logic [47:0] img;
        se6 = 1'b0;
        kd6 = 1'b1; kf = 1'b0; mode = 2'b01; cx = 4'd9; cy = 3'd0;
        step();
        total++; if (bz6 !== 1'b1) begin bad++; $display("FAIL range_busy_set got=%b want=1", bz6); end
        kd6 = 1'b0;
        step();
        total++; if (bz6 !== 1'b0) begin bad++; $display("FAIL range_busy_clr got=%b want=0", bz6); end
        se6 = 1'b1;
        kd6 = 1'b1; cx = 4'd1; cy = 3'd2;
        step();
        kd6 = 1'b0;
        step();
        kd6 = 1'b1; cx = 4'd0; cy = 3'd0;
        step();
        kd6 = 1'b0;
        step();
        img = '0;
        for (int i = 0; i < 48; i++) begin
            img[ph6] = out6;
            step();
        end
        total++; if (img !== 48'h2001) begin bad++; $display("FAIL range_board got=%h want=%h", img, 48'h2001); end
        total++; if (ph6o !== 7'(ph6)) begin bad++; $display("FAIL range_phase got=%0d want=%0d", ph6o, ph6); end
        se6 = 1'b0;
    endtask

    task automatic test_reset_mid_edit();
        int ones;
        se8 = 1'b0;
        kd8 = 1'b1; kf = 1'b0; mode = 2'b01; cx = 4'd6; cy = 3'd0;
        step();
        total++; if (bz8 !== 1'b1) begin bad++; $display("FAIL midrst_busy_set got=%b want=1", bz8); end
        kd8 = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL midrst_busy_async got=%b want=0", bz8); end
        step();
        rst_n = 1'b1;
        ph8 = 0; gc8 = 0; ph4 = 0; gc4 = 0; ph6 = 0;
        step();
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL midrst_busy_after got=%b want=0", bz8); end
        total++; if (ph8o !== 6'd0) begin bad++; $display("FAIL midrst_phase got=%0d want=0", ph8o); end
        se8 = 1'b1;
        ones = 0;
        repeat (64) begin
            if (out8 !== 1'b0) ones++;
            step();
        end
        total++; if (ones != 0) begin bad++; $display("FAIL midrst_ring_ones got=%0d want=0", ones); end
        se8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_recirc();
        test_lanes4();
        test_toggle_clear();
        test_busy_drop();
        test_range();
        test_reset_mid_edit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/life_ring_buf.md
# life_ring_buf

Parametrised Game-of-Life cell store: one X*Y-bit ring rotated LANES cells per enabled clock toward the update engine, with new-generation cells re-entering at the top. It succeeds the fixed one-bit-per-clock low/high split store. It tracks its own rotation phase so cursor edits land on absolute board coordinates regardless of rotation position. It supports set/clear/toggle/clear-all edit modes and reports generation boundaries and a generation count to the display/control logic.

## Interface
- X, 8, board width in cells
- Y, 8, board height in cells
- LOG2X, 3, cursor_x width; 2**LOG2X >= X
- LOG2Y, 3, cursor_y width; 2**LOG2Y >= Y
- LANES, 1, cells rotated per enabled clock; must divide X*Y (elaboration error otherwise)
- N (local), X*Y, ring length; PW (local), LOG2X+LOG2Y, phase width

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- shift_en  in  1  rotate ring by LANES this cycle
- in_bits  in  LANES  new cells entering at ring top (bit N-1 down)
- out_bits  out  LANES  ring bottom cells, = ring[LANES-1:0]
- key_flip  in  1  edit key level
- key_flip_d  in  1  key_flip delayed one clock by caller
- edit_mode  in  2  00 toggle, 01 set, 10 clear, 11 clear-all
- cursor_x  in  LOG2X  edit column
- cursor_y  in  LOG2Y  edit row
- phase  out  PW  cells rotated since last alignment, mod N
- gen_done  out  1  one-cycle pulse when phase wraps to 0
- gen_count  out  16  completed generations, wraps at 65535->0
- edit_busy  out  1  edit command pending

## Operation
- Ring: on shift_en, ring <= {in_bits, ring[N-1:LANES]}; phase <= (phase+LANES) mod N.
- Mapping: logical index L = cursor_y*X + cursor_x. At phase P it sits at physical (L - P) mod N. At phase 0, physical equals logical.
- Edit capture: key_flip_d && !key_flip (release edge) with edit_busy=0 latches edit_mode, L, and valid = (cursor_x<X && cursor_y<Y). edit_busy <= 1.
- Edit apply: the cycle after capture, edit_busy <= 0. If valid, the operation is applied to ring_next (post-shift value if shift_en is high) at physical (L - phase_next) mod N.
  - 00 toggle: invert the cell.
  - 01 set: force the cell to 1.
  - 10 clear: force the cell to 0.
  - 11 clear-all: ring_next forced to all zeros and gen_count <= 0; phase advances normally.
- Release edge while edit_busy=1 is dropped, no queueing.
- Out-of-range cursor: command consumed (busy pulses), ring unchanged.
- gen_done <= 1 in the cycle after the shift that makes phase_next == 0, else 0. gen_count increments in the same cycle except when clear-all is applied, where clear wins.
- Modulo arithmetic in PW+1 bits: add N when L - phase_next is negative. No power-of-two assumption on N.

## Timing
- Reset (async assert, sync-to-clock release): ring=0, phase=0, gen_count=0, gen_done=0, edit_busy=0, out_bits=0.
- out_bits is purely from the ring register: valid the whole cycle, changes only after a shift or edit edge.
- Edit latency: release edge sampled at edge k, capture at posedge k+1 (busy=1), cell updated at posedge k+2.
- Shift and edit in the same cycle: shift first, then edit on the shifted vector using phase_next; the addressed cell is always correct.
- Reset mid-edit: pending command discarded.
- in_bits that differ from out_bits (new generation) are not modified by the store. Edits to cells already re-entered apply to the new generation.

## Test plan
- Reset: hold reset=0 three clocks with shift_en=1 and random in_bits -> ring=0, phase=0, gen_count=0, gen_done=0, edit_busy=0.
- Recirculate, X=Y=8, LANES=1, in_bits=out_bits: shift to phase 5, then set cursor (2,1) -> after 5 further shifts out_bits=1. 64 shifts later out_bits=1 again, gen_done pulses once per 64 shifts.
- LANES=4, loopback, 32 shifts from reset -> phase sequence 0,4,...,60,0,4,...; gen_done two pulses; gen_count=2.
- Toggle at cursor (7,7) twice, then clear-all with shift_en=1 throughout -> cell 63 ends 0 after the toggles; after clear-all ring=0 and gen_count=0; phase keeps advancing.
- Second release edge during edit_busy -> dropped, only the first edit applied. Cursor (9,0) with X=6, LOG2X=4 -> busy pulses, ring unchanged.
- Reset asserted the cycle after capture -> no cell modified, edit_busy=0 after release.
